// File: rtl/imm_pkg.sv
// Shared types for the immediate-decode stage: format classes and RV opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imm_pkg;

  // Nine format classes need four bits; FMT_W sizes every port/reg that carries one.
  localparam int FMT_W = 4;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE = 4'd0,
    FMT_R    = 4'd1,
    FMT_I    = 4'd2,
    FMT_S    = 4'd3,
    FMT_B    = 4'd4,
    FMT_U    = 4'd5,
    FMT_J    = 4'd6,
    FMT_SH   = 4'd7,
    FMT_Z    = 4'd8
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode_comb.sv
// Purpose: pure combinational RV immediate decoder (instr -> imm, fmt, illegal).
// Latency: 0 cycles (combinational).
// Backpressure: none; no handshake of its own.
// Ports: instr in [31:0]; imm out [XLEN-1:0]; fmt out fmt_e; illegal out.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [31:0] imm32;
  logic [5:0]  shamt;
  logic [2:0]  funct3;
  logic [6:0]  opcode;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // RV64 shift amounts are six bits wide; RV32 ignores instr[25].
  assign shamt = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

  // Every format is built as a 32-bit value whose bit 31 is the correct sign
  // (zero-extended kinds are small and positive), then widened once below.
  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR, OPC_FENCE: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        fmt   = FMT_I;
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm32 = {26'b0, shamt};
          fmt   = FMT_SH;
        end else begin
          imm32 = {{20{instr[31]}}, instr[31:20]};
          fmt   = FMT_I;
        end
      end
      OPC_STORE: begin
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        fmt   = FMT_S;
      end
      OPC_BRANCH: begin
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        fmt   = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32 = {instr[31:12], 12'b0};
        fmt   = FMT_U;
      end
      OPC_JAL: begin
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        fmt   = FMT_J;
      end
      OPC_SYSTEM: begin
        // Only the immediate CSR forms carry an operand; ECALL/CSRRW etc. have none.
        if (funct3[2]) begin
          imm32 = {27'b0, instr[19:15]};
          fmt   = FMT_Z;
        end
      end
      OPC_OP: begin
        fmt = FMT_R;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  generate
    if (XLEN == 64) begin : g_x64
      assign imm = {{32{imm32[31]}}, imm32};
    end else begin : g_x32
      assign imm = imm32;
    end
  endgenerate

endmodule

// File: rtl/imm_decode_stage.sv
// Purpose: registered immediate-decode stage between fetch and execute, with 2-entry skid.
// Latency: 1 cycle from input handshake to out_valid; 1 beat/cycle while out_ready=1.
// Backpressure: in_ready is a flop (~skid_valid); a stalled output parks one more beat in skid.
// Ports: clk, rst_n (async low), flush; in_valid/in_ready/in_instr/in_pc;
//        out_valid/out_ready/out_imm/out_fmt/out_illegal/out_instr/out_pc.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [FMT_W-1:0] out_fmt,
  output logic             out_illegal,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc
);

  // Decode sits before the registers so both skid and output hold decoded beats.
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  logic            out_valid_q,   out_valid_d;
  logic [XLEN-1:0] out_imm_q,     out_imm_d;
  fmt_e            out_fmt_q,     out_fmt_d;
  logic            out_illegal_q, out_illegal_d;
  logic [31:0]     out_instr_q,   out_instr_d;
  logic [PC_W-1:0] out_pc_q,      out_pc_d;

  logic            skid_valid_q,   skid_valid_d;
  logic [XLEN-1:0] skid_imm_q,     skid_imm_d;
  fmt_e            skid_fmt_q,     skid_fmt_d;
  logic            skid_illegal_q, skid_illegal_d;
  logic [31:0]     skid_instr_q,   skid_instr_d;
  logic [PC_W-1:0] skid_pc_q,      skid_pc_d;

  logic accept;
  logic drain;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & ~skid_valid_q;
  assign drain    = out_valid_q & out_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_imm_d      = out_imm_q;
    out_fmt_d      = out_fmt_q;
    out_illegal_d  = out_illegal_q;
    out_instr_d    = out_instr_q;
    out_pc_d       = out_pc_q;
    skid_valid_d   = skid_valid_q;
    skid_imm_d     = skid_imm_q;
    skid_fmt_d     = skid_fmt_q;
    skid_illegal_d = skid_illegal_q;
    skid_instr_d   = skid_instr_q;
    skid_pc_d      = skid_pc_q;

    if (flush) begin
      // Everything buffered and anything offered this cycle is dropped.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Skid full implies in_ready=0, so the only event is the older beat moving up.
      if (drain) begin
        out_valid_d   = 1'b1;
        out_imm_d     = skid_imm_q;
        out_fmt_d     = skid_fmt_q;
        out_illegal_d = skid_illegal_q;
        out_instr_d   = skid_instr_q;
        out_pc_d      = skid_pc_q;
        skid_valid_d  = 1'b0;
      end
    end else if (!out_valid_q || drain) begin
      // Output slot free (or freeing): new beat bypasses the skid.
      out_valid_d = accept;
      if (accept) begin
        out_imm_d     = dec_imm;
        out_fmt_d     = dec_fmt;
        out_illegal_d = dec_illegal;
        out_instr_d   = in_instr;
        out_pc_d      = in_pc;
      end
    end else if (accept) begin
      skid_valid_d   = 1'b1;
      skid_imm_d     = dec_imm;
      skid_fmt_d     = dec_fmt;
      skid_illegal_d = dec_illegal;
      skid_instr_d   = in_instr;
      skid_pc_d      = in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_imm_q      <= '0;
      out_fmt_q      <= FMT_NONE;
      out_illegal_q  <= 1'b0;
      out_instr_q    <= '0;
      out_pc_q       <= '0;
      skid_valid_q   <= 1'b0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= FMT_NONE;
      skid_illegal_q <= 1'b0;
      skid_instr_q   <= '0;
      skid_pc_q      <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_imm_q      <= out_imm_d;
      out_fmt_q      <= out_fmt_d;
      out_illegal_q  <= out_illegal_d;
      out_instr_q    <= out_instr_d;
      out_pc_q       <= out_pc_d;
      skid_valid_q   <= skid_valid_d;
      skid_imm_q     <= skid_imm_d;
      skid_fmt_q     <= skid_fmt_d;
      skid_illegal_q <= skid_illegal_d;
      skid_instr_q   <= skid_instr_d;
      skid_pc_q      <= skid_pc_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_illegal_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;

endmodule
